// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer with FWFT byte FIFO, sticky overflow and idle-gap frame_end.
// Define UART_RX_CTRL_STATS_EN to add saturating byte_cnt/drop_cnt statistics outputs.
module uart_rx_ctrl #(
   parameter int DEPTH    = 16,
   parameter int AW       = 4,
   parameter int IDLE_TMO = 1000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   input  logic          flush,
   input  logic          rx_done,
   input  logic [7:0]    rx_data,
   output logic          rx_rst,
   output logic [7:0]    m_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic          frame_end,
   output logic          overflow,
   input  logic          ovf_clr,
   output logic [AW:0]   level
`ifdef UART_RX_CTRL_STATS_EN
   ,
   output logic [15:0]   byte_cnt,
   output logic [15:0]   drop_cnt
`endif
);
   localparam int CW = $clog2(IDLE_TMO);
   typedef enum logic [1:0] {OFF, ARM, RUN, FLUSH} state_t;
   state_t        state_q, state_d;
   logic          arm_cnt_q, arm_cnt_d;
   logic          rx_done_q;
   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          ovf_q, ovf_d;
   logic          armed_q, armed_d;
   logic [CW-1:0] idle_q, idle_d;
   logic          act, rx_edge, pop, full, push, drop;
   always_comb begin
      state_d = state_q;
      case (state_q)
         OFF:     state_d = enable ? ARM : OFF;
         ARM:     state_d = !enable ? OFF : (arm_cnt_q ? RUN : ARM);
         RUN:     state_d = !enable ? OFF : (flush ? FLUSH : RUN);
         default: state_d = enable ? ARM : OFF;
      endcase
   end
   // the arm counter only runs inside ARM, so every entry into ARM starts at zero
   assign arm_cnt_d = (state_q == ARM) && enable && !arm_cnt_q;
   assign rx_rst    = (state_q != RUN);
   assign act       = (state_q == RUN) && enable && !flush;
   assign rx_edge   = act && rx_done && !rx_done_q;
   assign m_valid   = (level_q != '0);
   assign m_data    = mem_q[rd_ptr_q];
   assign level     = level_q;
   assign overflow  = ovf_q;
   assign pop       = m_valid && m_ready;
   assign full      = (level_q == (AW+1)'(DEPTH));
   assign push      = rx_edge && (!full || pop);
   assign drop      = rx_edge && full && !pop;
   assign frame_end = act && armed_q && !rx_edge && (idle_q == CW'(IDLE_TMO - 1));
   always_comb begin
      wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
      rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
      level_d  = flush ? '0 : level_q + (AW+1)'(push) - (AW+1)'(pop);
      ovf_d    = drop || (ovf_q && !ovf_clr);
      armed_d  = act && (rx_edge || (armed_q && !frame_end));
      idle_d   = (!act || rx_edge || frame_end) ? '0 : (armed_q ? idle_q + CW'(1) : idle_q);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= OFF;
         arm_cnt_q <= 1'b0;
         rx_done_q <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         ovf_q     <= 1'b0;
         armed_q   <= 1'b0;
         idle_q    <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         arm_cnt_q <= arm_cnt_d;
         rx_done_q <= rx_rst ? 1'b0 : rx_done;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         ovf_q     <= ovf_d;
         armed_q   <= armed_d;
         idle_q    <= idle_d;
         if (push) mem_q[wr_ptr_q] <= rx_data;
      end
   end
`ifdef UART_RX_CTRL_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byte_cnt <= '0;
         drop_cnt <= '0;
      end else begin
         if (push && byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
         if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
   end
`endif
endmodule
